// File: rtl/cc_uart_pkg.sv
// Shared types and constants for the cc_uart receiver/transmitter family.
// Optional feature macro: CC_UART_PARITY_EN (adds the even-parity state).
package cc_uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 434;
    localparam int BAUD_CNT_W           = 12;

`ifdef CC_UART_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_e;
`endif

endpackage

// File: rtl/cc_uart_rx_if.sv
// Byte-side handshake and status bundle of the UART receiver.
// Optional feature macro: CC_UART_PARITY_EN (adds rx_parity_err).
interface cc_uart_rx_if;

    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_done;
    logic       rx_busy;
    logic       rx_frame_err;
    logic       rx_overrun;
`ifdef CC_UART_PARITY_EN
    logic       rx_parity_err;
`endif

    // master: the receiver producing bytes; slave: the consumer.
    modport master (
        input  rx_ready,
        output rx_data, rx_valid, rx_done, rx_busy, rx_frame_err, rx_overrun
`ifdef CC_UART_PARITY_EN
        , output rx_parity_err
`endif
    );

    modport slave (
        output rx_ready,
        input  rx_data, rx_valid, rx_done, rx_busy, rx_frame_err, rx_overrun
`ifdef CC_UART_PARITY_EN
        , input rx_parity_err
`endif
    );

endinterface

// File: rtl/cc_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Reset value is a parameter so idle-high and idle-low lines both fit.
module cc_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/cc_uart.sv
// UART receiver: 8 data bits, LSB first, one stop bit, mid-bit sampling.
// Optional feature macro: CC_UART_PARITY_EN (even parity bit before stop).
module cc_uart_rx
    import cc_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_in,
    cc_uart_rx_if.master rx_if
);

    localparam logic [BAUD_CNT_W-1:0] BIT_LAST  = BAUD_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_CNT_W-1:0] HALF_LAST = BAUD_CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic rx_sync;

    cc_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rx_in),
        .q_o   (rx_sync)
    );

    rx_state_e             state_q, state_d;
    logic [BAUD_CNT_W-1:0] baud_q, baud_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            shift_q, shift_d;
    logic [7:0]            data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;
    logic                  ferr_q, ferr_d;
    logic                  ovr_q, ovr_d;
`ifdef CC_UART_PARITY_EN
    logic                  par_bad_q, par_bad_d;
    logic                  perr_q, perr_d;
`endif
    logic                  byte_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef CC_UART_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
`ifdef CC_UART_PARITY_EN
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

`ifdef CC_UART_PARITY_EN
    assign byte_ok = !par_bad_q;
`else
    assign byte_ok = 1'b1;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_d   = state_q;
        baud_d    = baud_q + 12'd1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;
        ovr_d     = ovr_q;
`ifdef CC_UART_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif

        if (valid_q && rx_if.rx_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (!rx_sync) begin
                    state_d = ST_START;
                    bit_d   = '0;
                end
            end
            ST_START: begin
                if (baud_q == HALF_LAST) begin
                    baud_d  = '0;
                    state_d = rx_sync ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_q == BIT_LAST) begin
                    baud_d  = '0;
                    shift_d = {rx_sync, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef CC_UART_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef CC_UART_PARITY_EN
            ST_PARITY: begin
                if (baud_q == BIT_LAST) begin
                    baud_d    = '0;
                    par_bad_d = rx_sync ^ (^shift_q);
                    state_d   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (baud_q == BIT_LAST) begin
                    baud_d  = '0;
                    state_d = ST_IDLE;
`ifdef CC_UART_PARITY_EN
                    perr_d  = par_bad_q;
`endif
                    if (rx_sync) begin
                        done_d = 1'b1;
                        if (byte_ok) begin
                            // A consume in this same cycle frees the slot, so no overrun.
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            if (valid_q && !rx_if.rx_ready) begin
                                ovr_d = 1'b1;
                            end
                        end
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rx_if.rx_data      = data_q;
    assign rx_if.rx_valid     = valid_q;
    assign rx_if.rx_done      = done_q;
    assign rx_if.rx_busy      = (state_q != ST_IDLE);
    assign rx_if.rx_frame_err = ferr_q;
    assign rx_if.rx_overrun   = ovr_q;
`ifdef CC_UART_PARITY_EN
    assign rx_if.rx_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_cc_uart_rx.sv
// Directed self-checking bench for cc_uart_rx at 16 clocks per bit.
// Define CC_UART_PARITY_EN to also exercise the parity build.
module tb_cc_uart_rx;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_in = 1'b1;

    cc_uart_rx_if rx_if ();

    cc_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx_in (rx_in),
        .rx_if (rx_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Event counters owned by the monitor; scenarios compare deltas.
    int         done_cnt  = 0;
    int         ferr_cnt  = 0;
    int         valid_cyc = 0;
    int         busy_cyc  = 0;
    logic [7:0] done_data = 8'h00;
`ifdef CC_UART_PARITY_EN
    int         perr_cnt  = 0;
    logic       par_flip  = 1'b0;
    int         b_perr;
`endif

    int b_done, b_ferr, b_valid, b_busy;

    always @(negedge clk) begin
        if (rx_if.rx_done) begin
            done_cnt  <= done_cnt + 1;
            done_data <= rx_if.rx_data;
        end
        if (rx_if.rx_frame_err) ferr_cnt  <= ferr_cnt + 1;
        if (rx_if.rx_valid)     valid_cyc <= valid_cyc + 1;
        if (rx_if.rx_busy)      busy_cyc  <= busy_cyc + 1;
`ifdef CC_UART_PARITY_EN
        if (rx_if.rx_parity_err) perr_cnt <= perr_cnt + 1;
`endif
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic snapshot();
        @(negedge clk);
        b_done  = done_cnt;
        b_ferr  = ferr_cnt;
        b_valid = valid_cyc;
        b_busy  = busy_cyc;
`ifdef CC_UART_PARITY_EN
        b_perr  = perr_cnt;
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        rx_in = b;
        repeat (CPB - 1) @(negedge clk);
    endtask

    // rst_bit >= 0 pulses rst_n low for two cycles inside that data bit.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int rst_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == rst_bit) begin
                @(negedge clk);
                rx_in = d[i];
                repeat (3) @(negedge clk);
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                repeat (CPB - 6) @(negedge clk);
            end else begin
                send_bit(d[i]);
            end
        end
`ifdef CC_UART_PARITY_EN
        send_bit((^d) ^ par_flip);
`endif
        send_bit(stop);
        @(negedge clk);
        rx_in = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rx_if.rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data",     rx_if.rx_data,      8'h00);
        check("rst_valid",    rx_if.rx_valid,     1'b0);
        check("rst_busy",     rx_if.rx_busy,      1'b0);
        check("rst_done",     rx_if.rx_done,      1'b0);
        check("rst_ferr",     rx_if.rx_frame_err, 1'b0);
        check("rst_overrun",  rx_if.rx_overrun,   1'b0);
        rst_n = 1'b1;
        idle(4);

        // Good frame, consumer always ready.
        rx_if.rx_ready = 1'b1;
        snapshot();
        send_frame(8'hA5, 1'b1, -1);
        idle(6);
        check("a5_done_cnt",  done_cnt - b_done,   1);
        check("a5_done_data", done_data,           8'hA5);
        check("a5_data",      rx_if.rx_data,       8'hA5);
        check("a5_valid_cyc", valid_cyc - b_valid, 1);
        check("a5_ferr_cnt",  ferr_cnt - b_ferr,   0);
        check("a5_overrun",   rx_if.rx_overrun,    1'b0);
        check("a5_busy",      rx_if.rx_busy,       1'b0);

        // Short low glitch on an idle line.
        snapshot();
        @(negedge clk);
        rx_in = 1'b0;
        idle(5);
        rx_in = 1'b1;
        idle(30);
        check("gl_busy_seen", (busy_cyc - b_busy) > 0, 1'b1);
        check("gl_busy",      rx_if.rx_busy,           1'b0);
        check("gl_done_cnt",  done_cnt - b_done,       0);
        check("gl_ferr_cnt",  ferr_cnt - b_ferr,       0);

        // Stop bit low: frame error, held byte untouched.
        snapshot();
        send_frame(8'h3C, 1'b0, -1);
        idle(40);
        check("fe_ferr_cnt",  ferr_cnt - b_ferr,  1);
        check("fe_done_cnt",  done_cnt - b_done,  0);
        check("fe_data",      rx_if.rx_data,      8'hA5);
        check("fe_valid",     rx_if.rx_valid,     1'b0);
        check("fe_busy",      rx_if.rx_busy,      1'b0);

        // Two back-to-back bytes with nobody consuming.
        rx_if.rx_ready = 1'b0;
        snapshot();
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, -1);
        idle(6);
        check("ov_done_cnt",  done_cnt - b_done,  2);
        check("ov_data",      rx_if.rx_data,      8'h22);
        check("ov_valid",     rx_if.rx_valid,     1'b1);
        check("ov_overrun",   rx_if.rx_overrun,   1'b1);

        // Reset in bit 4 of 0xFF, then a clean 0x5A.
        rx_if.rx_ready = 1'b1;
        idle(4);
        snapshot();
        send_frame(8'hFF, 1'b1, 4);
        idle(2);
        check("rr_overrun",   rx_if.rx_overrun,   1'b0);
        check("rr_data",      rx_if.rx_data,      8'h00);
        check("rr_busy",      rx_if.rx_busy,      1'b0);
        send_frame(8'h5A, 1'b1, -1);
        idle(6);
        check("rr_done_cnt",  done_cnt - b_done,   1);
        check("rr_done_data", done_data,           8'h5A);
        check("rr_data2",     rx_if.rx_data,       8'h5A);
        check("rr_valid_cyc", valid_cyc - b_valid, 1);
        check("rr_ferr_cnt",  ferr_cnt - b_ferr,   0);
        check("rr_overrun2",  rx_if.rx_overrun,    1'b0);

`ifdef CC_UART_PARITY_EN
        // 0x07 has three ones, so the even-parity bit is 1.
        rx_if.rx_ready = 1'b0;
        par_flip = 1'b1;
        snapshot();
        send_frame(8'h07, 1'b1, -1);
        idle(6);
        check("pe_perr_cnt",  perr_cnt - b_perr,  1);
        check("pe_valid",     rx_if.rx_valid,     1'b0);
        check("pe_data",      rx_if.rx_data,      8'h5A);
        par_flip = 1'b0;
        snapshot();
        send_frame(8'h07, 1'b1, -1);
        idle(6);
        check("pg_perr_cnt",  perr_cnt - b_perr,  0);
        check("pg_data",      rx_if.rx_data,      8'h07);
        check("pg_valid",     rx_if.rx_valid,     1'b1);
        rx_if.rx_ready = 1'b1;
        idle(4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cc_uart_rx.md
CC_UART_RX -- requirements
Module: cc_uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clock cycles per UART bit (legal range 4..4095).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port rx_in  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port rx_ready  input  1  consumer accepts held byte when high with rx_valid.
REQ-006 SHALL have port rx_data  output  8  last received byte.
REQ-007 SHALL have port rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-008 SHALL have port rx_done  output  1  one-cycle pulse on every good stop bit.
REQ-009 SHALL have port rx_busy  output  1  high in any state other than IDLE.
REQ-010 SHALL have port rx_frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-011 SHALL have port rx_overrun  output  1  sticky; set when a byte completes while rx_valid is high.

Function
REQ-012 SHALL pass rx_in through a 2-flop synchronizer; the synchronized line is the only sampled signal.
REQ-013 SHALL implement states IDLE, START, DATA, STOP, plus PARITY only under REQ-027.
REQ-014 IDLE->START when the synchronized line is 0; bit counter cleared.
REQ-015 START: after CLKS_PER_BIT/2 cycles (integer division), sample; 0 -> DATA, 1 -> IDLE (glitch rejected, no flags).
REQ-016 DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first, shifted into an internal shift register.
REQ-017 STOP: sample after CLKS_PER_BIT cycles; 1 -> load rx_data, pulse rx_done, set rx_valid; 0 -> pulse rx_frame_err, rx_data/rx_valid unchanged.
REQ-018 After STOP, SHALL return to IDLE the following cycle, so a back-to-back start bit is detected without a gap.
REQ-019 Output timing: rx_done, rx_frame_err, and rx_valid rise on the cycle after the stop-bit sample.
REQ-020 rx_valid SHALL clear on the cycle after a clock edge with rx_valid and rx_ready both high.
REQ-021 If a good stop bit occurs while rx_valid is high and not consumed that same cycle, SHALL overwrite rx_data, keep rx_valid high, and set rx_overrun.
REQ-022 Simultaneous consume and new byte in one cycle: the new byte wins; rx_valid stays high; no overrun.
REQ-023 rx_overrun SHALL clear only on reset.
REQ-024 Baud counter width SHALL be 12 bits; the counter wraps to 0 at each sample point.

Reset
REQ-025 On rst_n low at a clk edge: state IDLE, counters 0, synchronizer flops 1, rx_data 8'h00, and rx_valid, rx_done, rx_busy, rx_frame_err, rx_overrun all 0.
REQ-026 Reset mid-frame SHALL abandon the frame with no flag pulses; reception resumes on the next falling edge after release.

Configuration
REQ-027 With CC_UART_PARITY_EN defined, SHALL add output rx_parity_err (1 bit) and a PARITY state between DATA and STOP that samples an even-parity bit.
REQ-028 On parity mismatch, SHALL pulse rx_parity_err at the REQ-019 timing and SHALL NOT load rx_data or set rx_valid; the STOP state still runs.
REQ-029 With CC_UART_PARITY_EN undefined, SHALL have no parity port, no PARITY state, and a 10-bit frame.

Structure
REQ-030 Package cc_uart_pkg SHALL hold the state enum typedef, the default CLKS_PER_BIT constant, and the baud counter width constant.
REQ-031 The synchronizer SHALL be sub-module cc_sync2 (2 flops, reset value parameterized), reusable by the transmitter side.

Verification (CLKS_PER_BIT=16)
REQ-032 Frame 8'hA5 with good stop and rx_ready=1 -> rx_done pulse, rx_data=8'hA5, rx_valid high exactly one cycle.
REQ-033 Low glitch of 5 cycles on idle line -> returns to IDLE; rx_busy falls; no rx_done or rx_frame_err.
REQ-034 Frame 8'h3C with stop bit low -> rx_frame_err pulse; rx_data keeps its previous value; rx_valid 0.
REQ-035 Bytes 8'h11 then 8'h22 back-to-back with rx_ready=0 -> rx_data=8'h22, rx_valid=1, rx_overrun=1.
REQ-036 rst_n low during bit 4 of 8'hFF, then frame 8'h5A -> only 8'h5A delivered, no flags.
REQ-037 With CC_UART_PARITY_EN: 8'h07 with parity bit 0 -> rx_parity_err pulse, rx_valid 0; with parity bit 1 -> rx_data=8'h07, rx_valid 1.
